// File: rtl/nios_hps_system_nios_keys.sv
// Avalon-MM input port for pushbuttons/switches: synchronizer, per-bit debounce,
// edge capture with per-bit interrupt mask and a level irq.
module nios_hps_system_nios_keys #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter string       EDGE_TYPE       = "FALLING",
  parameter logic [31:0] IN_RESET_VALUE  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RstVal   = IN_RESET_VALUE[WIDTH-1:0];
  localparam bit               EdgeRise = (EDGE_TYPE == "RISING") || (EDGE_TYPE == "ANY");
  localparam bit               EdgeFall = (EDGE_TYPE == "FALLING") || (EDGE_TYPE == "ANY");

  localparam logic [1:0] AddrData  = 2'd0;
  localparam logic [1:0] AddrRsvd  = 2'd1;
  localparam logic [1:0] AddrMask  = 2'd2;
  localparam logic [1:0] AddrEdge  = 2'd3;

  logic [WIDTH-1:0]           sync1_q, sync1_d;
  logic [WIDTH-1:0]           sync2_q, sync2_d;
  logic [WIDTH-1:0]           stable_q, stable_d;
  logic [WIDTH-1:0]           stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           irqmask_q, irqmask_d;
  logic [WIDTH-1:0]           edgecap_q, edgecap_d;

  logic             wr_en;
  logic [WIDTH-1:0] rise, fall, edge_det;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    sync1_d      = in_port;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
  end

  // A bit must differ from stable for DEBOUNCE_CYCLES consecutive samples before it is accepted;
  // any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_comb begin
    rise     = stable_q & ~stable_dly_q;
    fall     = ~stable_q & stable_dly_q;
    edge_det = '0;
    if (EdgeRise) edge_det = edge_det | rise;
    if (EdgeFall) edge_det = edge_det | fall;
  end

  // Clear is applied before set so a simultaneous capture survives the write-1-to-clear.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (address == AddrMask)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == AddrEdge)) begin
      edgecap_d = edgecap_d & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_det;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= RstVal;
      sync2_q      <= RstVal;
      stable_q     <= RstVal;
      stable_dly_q <= RstVal;
      cnt_q        <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      AddrData: readdata = 32'(stable_q);
      AddrRsvd: readdata = '0;
      AddrMask: readdata = 32'(irqmask_q);
      AddrEdge: readdata = 32'(edgecap_q);
      default:  readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_hps_system_nios_keys.sv
// Directed bench for the keys input port: WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture.
module tb_nios_hps_system_nios_keys;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int vectors;
  int miscompares;

  nios_hps_system_nios_keys #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      ("FALLING"),
    .IN_RESET_VALUE (32'hFFFFFFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    in_port = 4'hF;
    reset   = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h0000000F) begin
      miscompares++;
      $display("FAIL reset_data: got %h want %h", d, 32'h0000000F);
    end
    rd(2'd1, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rsvd: got %h want %h", d, 32'h0);
    end
    rd(2'd2, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mask: got %h want %h", d, 32'h0);
    end
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_edge: got %h want %h", d, 32'h0);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    in_port = 4'hE;
    tick(3);
    in_port = 4'hF;
    tick(10);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h0000000F) begin
      miscompares++;
      $display("FAIL glitch_data: got %h want %h", d, 32'h0000000F);
    end
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL glitch_edge: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_debounce;
    logic [31:0] d;
    in_port = 4'hE;
    tick(5);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h0000000F) begin
      miscompares++;
      $display("FAIL deb_early: got %h want %h", d, 32'h0000000F);
    end
    tick(1);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h0000000E) begin
      miscompares++;
      $display("FAIL deb_latency: got %h want %h", d, 32'h0000000E);
    end
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL deb_edge_early: got %h want %h", d, 32'h0);
    end
    tick(1);
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL deb_edge: got %h want %h", d, 32'h1);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL deb_irq_masked: got %b want 0", irq);
    end
    tick(3);
  endtask

  task automatic test_irq;
    logic [31:0] d;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_before_mask: got %b want 0", irq);
    end
    wr(2'd2, 32'hFFFF_FFF1);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_after_mask: got %b want 1", irq);
    end
    rd(2'd2, d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL irq_mask_read: got %h want %h", d, 32'h1);
    end
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hF);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h0000000E) begin
      miscompares++;
      $display("FAIL irq_data_write_ignored: got %h want %h", d, 32'h0000000E);
    end
    wr(2'd3, 32'h1);
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL irq_w1c: got %h want %h", d, 32'h0);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_cleared: got %b want 0", irq);
    end
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    in_port = 4'hC;
    tick(6);
    wr(2'd3, 32'h2);
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h2) begin
      miscompares++;
      $display("FAIL setwins_edge: got %h want %h", d, 32'h2);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL setwins_irq_masked: got %b want 0", irq);
    end
    wr(2'd3, 32'h2);
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL setwins_clear_after: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_reset_mid_debounce;
    logic [31:0] d;
    wr(2'd2, 32'hF);
    in_port = 4'h4;
    tick(4);
    reset = 1'b1;
    tick(1);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h0000000F) begin
      miscompares++;
      $display("FAIL midrst_data: got %h want %h", d, 32'h0000000F);
    end
    rd(2'd2, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_mask: got %h want %h", d, 32'h0);
    end
    rd(2'd3, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_edge: got %h want %h", d, 32'h0);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_irq: got %b want 0", irq);
    end
    reset = 1'b0;
    tick(5);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h0000000F) begin
      miscompares++;
      $display("FAIL midrst_early: got %h want %h", d, 32'h0000000F);
    end
    tick(1);
    rd(2'd0, d);
    vectors++;
    if (d !== 32'h00000004) begin
      miscompares++;
      $display("FAIL midrst_latency: got %h want %h", d, 32'h00000004);
    end
    tick(1);
    rd(2'd3, d);
    vectors++;
    if (d !== 32'hB) begin
      miscompares++;
      $display("FAIL midrst_edge_after: got %h want %h", d, 32'hB);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_irq_after: got %b want 0", irq);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    in_port     = 4'hF;
    test_reset();
    test_glitch();
    test_debounce();
    test_irq();
    test_set_wins();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
